// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns EX/MEM load/store requests into a single
// req/ack bus transaction, aligns/extends load data and stalls the pipeline.
module mem_access_unit #(
  parameter int TIMEOUT = 16  // must be >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [1:0]  size_in,
  input  logic        signed_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] mem_out,
  output logic        stall,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [1:0]      size_q;
  logic [1:0]      off_q;
  logic            signed_q;
  logic            acc;
  logic            misaligned;
  logic            timeout_hit;
  logic [3:0]      be_c;
  logic [31:0]     wdata_c;

  assign acc         = valid_in & (MemRead_in | MemWrite_in);
  // Size 11 decodes as word, so size_in[1] alone selects the word check.
  assign misaligned  = ((size_in == 2'b01) & addr_in[0]) |
                       (size_in[1] & (addr_in[1:0] != 2'b00));
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  function automatic logic [31:0] extract(input logic [31:0] d,
                                          input logic [1:0]  sz,
                                          input logic [1:0]  off,
                                          input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*off +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (sz)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return d;
    endcase
  endfunction

  // Byte-lane enables and replicated store data; reads use the same enables.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata_in;
    case (size_in)
      2'b00: begin
        be_c    = 4'b0001 << addr_in[1:0];
        wdata_c = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        be_c    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata_in[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, regardless of block evaluation order.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; any path that
    // skipped an assignment would otherwise infer a latch.
    state_next   = state;
    stall        = 1'b0;
    misalign_err = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (misaligned) begin
            misalign_err = 1'b1;
          end else begin
            stall      = 1'b1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (bus_ack || timeout_hit) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      mem_out   <= '0;
      bus_err   <= 1'b0;
      cnt       <= '0;
      size_q    <= '0;
      off_q     <= '0;
      signed_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc && !misaligned) begin
            bus_addr  <= {addr_in[31:2], 2'b00};
            bus_we    <= MemWrite_in;  // write wins when both are set
            bus_be    <= be_c;
            bus_wdata <= wdata_c;
            size_q    <= size_in;
            off_q     <= addr_in[1:0];
            signed_q  <= signed_in;
            bus_req   <= 1'b1;
            cnt       <= '0;
          end else if (acc) begin
            mem_out <= '0;
          end
        end
        BUSY: begin
          // Ack is tested first so an ack on the last allowed cycle succeeds.
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) mem_out <= extract(bus_rdata, size_q, off_q, signed_q);
          end else if (timeout_hit) begin
            bus_req <= 1'b0;
            mem_out <= '0;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    bus_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected MEM/WB results are queued as each
// access is issued and compared when the unit drops stall in its response cycle.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [1:0]  size_in;
  logic        signed_in;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] mem_out;
  logic        stall;
  logic        misalign_err;
  logic        bus_err;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .size_in(size_in), .signed_in(signed_in), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .mem_out(mem_out), .stall(stall), .misalign_err(misalign_err),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mem;
    logic        err;
    int          stall_len;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Response monitor: a falling stall edge marks the RESP cycle.
  logic prev_stall = 1'b0;
  int   run_len    = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_en && prev_stall && !stall) begin
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL sb_underflow: observed response with empty scoreboard");
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("resp/mem_out",   mem_out,          mon_e.mem);
        check("resp/bus_err",   32'(bus_err),     32'(mon_e.err));
        check("resp/stall_len", 32'(run_len),     32'(mon_e.stall_len));
      end
    end
    run_len    = stall ? run_len + 1 : 0;
    prev_stall = stall;
  end

  task automatic idle();
    valid_in    = 1'b0;
    MemRead_in  = 1'b0;
    MemWrite_in = 1'b0;
  endtask

  // Starts in IDLE at posedge+2 and returns in IDLE at posedge+2 with the
  // instruction still presented. ack_wait >= TO means no ack (timeout).
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] sz, input logic sg, input int ack_wait,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input logic [31:0] exp_mem,
                           input logic exp_err);
    exp_t e;
    valid_in = 1'b1; MemRead_in = rd; MemWrite_in = wr;
    addr_in = addr; wdata_in = wd; size_in = sz; signed_in = sg;
    e.mem = exp_mem;
    e.err = exp_err;
    e.stall_len = 1 + ((ack_wait >= TO) ? TO : ack_wait + 1);
    sb.push_back(e);
    #1;
    check({tag, "/idle_stall"},    32'(stall),        32'd1);
    check({tag, "/idle_misalign"}, 32'(misalign_err), 32'd0);
    @(posedge clk); #2;
    check({tag, "/req"},  32'(bus_req), 32'd1);
    check({tag, "/addr"}, bus_addr,     {addr[31:2], 2'b00});
    check({tag, "/we"},   32'(bus_we),  32'(wr));
    check({tag, "/be"},   32'(bus_be),  32'(exp_be));
    if (wr) check({tag, "/wdata"}, bus_wdata, exp_wd);
    if (ack_wait >= TO) begin
      repeat (TO - 1) begin @(posedge clk); #2; end
      check({tag, "/req_last_busy"}, 32'(bus_req), 32'd1);
      @(posedge clk); #2;
    end else begin
      repeat (ack_wait) begin @(posedge clk); #2; end
      bus_ack = 1'b1; bus_rdata = rdata;
      @(posedge clk); #2;
      bus_ack = 1'b0; bus_rdata = '0;
    end
    check({tag, "/resp_req"},   32'(bus_req), 32'd0);
    check({tag, "/resp_stall"}, 32'(stall),   32'd0);
    @(posedge clk); #2;
    check({tag, "/no_launch_from_resp"}, 32'(bus_req), 32'd0);
    check({tag, "/err_cleared"},         32'(bus_err), 32'd0);
  endtask

  initial begin
    reset = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    addr_in = '0; wdata_in = '0; size_in = '0; signed_in = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    check("rst/bus_req", 32'(bus_req), 32'd0);
    check("rst/mem_out", mem_out,      32'd0);
    check("rst/stall",   32'(stall),   32'd0);
    check("rst/bus_err", 32'(bus_err), 32'd0);
    check("rst/bus_be",  32'(bus_be),  32'd0);
    check("rst/bus_addr", bus_addr,    32'd0);
    reset = 1'b1;
    @(posedge clk); #2;
    mon_en = 1'b1;

    do_access("lw",   1, 0, 32'h100, 32'h0, 2'b10, 0, 0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF, 0);
    do_access("lb",   1, 0, 32'h103, 32'h0, 2'b00, 1, 1, 32'h80FF1234, 4'b1000, 32'h0, 32'hFFFFFF80, 0);
    do_access("lbu",  1, 0, 32'h103, 32'h0, 2'b00, 0, 0, 32'h80FF1234, 4'b1000, 32'h0, 32'h00000080, 0);
    do_access("lh",   1, 0, 32'h102, 32'h0, 2'b01, 1, 0, 32'h80FF1234, 4'b1100, 32'h0, 32'hFFFF80FF, 0);
    do_access("lhu",  1, 0, 32'h100, 32'h0, 2'b01, 0, 0, 32'h80FF1234, 4'b0011, 32'h0, 32'h00001234, 0);
    do_access("tmo",  1, 0, 32'h400, 32'h0, 2'b10, 0, TO, 32'h0,       4'b1111, 32'h0, 32'h00000000, 1);
    do_access("ack_last", 1, 0, 32'h404, 32'h0, 2'b10, 0, TO - 1, 32'h12345678, 4'b1111, 32'h0, 32'h12345678, 0);
    do_access("sh",   0, 1, 32'h206, 32'h0000ABCD, 2'b01, 0, 3, 32'h0, 4'b1100, 32'hABCDABCD, 32'h12345678, 0);
    do_access("sb",   0, 1, 32'h201, 32'h0000005A, 2'b00, 0, 0, 32'h0, 4'b0010, 32'h5A5A5A5A, 32'h12345678, 0);
    do_access("rw_both", 1, 1, 32'h500, 32'h11223344, 2'b10, 0, 0, 32'hFFFFFFFF, 4'b1111, 32'h11223344, 32'h12345678, 0);

    // Reset mid-transaction, then a stray ack after reset is released.
    valid_in = 1'b1; MemRead_in = 1'b1; addr_in = 32'h300; size_in = 2'b10;
    @(posedge clk); #2;
    check("rstmid/req_before", 32'(bus_req), 32'd1);
    idle();
    reset = 1'b0; mon_en = 1'b0;
    @(posedge clk); #2;
    check("rstmid/req",     32'(bus_req), 32'd0);
    check("rstmid/stall",   32'(stall),   32'd0);
    check("rstmid/mem_out", mem_out,      32'd0);
    reset = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(posedge clk); #2;
    bus_ack = 1'b0; bus_rdata = '0;
    check("stray_ack/req",     32'(bus_req), 32'd0);
    check("stray_ack/mem_out", mem_out,      32'd0);
    check("stray_ack/stall",   32'(stall),   32'd0);
    check("stray_ack/bus_err", 32'(bus_err), 32'd0);
    mon_en = 1'b1;

    do_access("lw_after_rst", 1, 0, 32'h104, 32'h0, 2'b10, 0, 0, 32'hCAFEF00D, 4'b1111, 32'h0, 32'hCAFEF00D, 0);

    // Misaligned word load: flagged, no stall, no bus activity, mem_out cleared.
    valid_in = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b0;
    addr_in = 32'h101; size_in = 2'b10; signed_in = 1'b0;
    #1;
    check("mis_lw/err",   32'(misalign_err), 32'd1);
    check("mis_lw/stall", 32'(stall),        32'd0);
    @(posedge clk); #2;
    check("mis_lw/req",     32'(bus_req), 32'd0);
    check("mis_lw/mem_out", mem_out,      32'd0);
    MemRead_in = 1'b0; MemWrite_in = 1'b1; addr_in = 32'h203; size_in = 2'b01;
    #1;
    check("mis_sh/err", 32'(misalign_err), 32'd1);
    idle();
    #1;
    check("idle/err", 32'(misalign_err), 32'd0);
    @(posedge clk); #2;
    check("mis/req_never", 32'(bus_req), 32'd0);
    check("mis/stall",     32'(stall),   32'd0);

    @(posedge clk); #2;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
